// File: rtl/ex_div_unit.sv
// Iterative RV32M divider for the EX stage: restoring radix-2, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU, divide-by-zero and signed overflow, with FLUSH and BUSY stall.
module ex_div_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [1:0]      DIV_OP,
    input  logic [XLEN-1:0] DIVIDEND,
    input  logic [XLEN-1:0] DIVISOR,
    input  logic [4:0]      DEST_REG,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      OUT_DEST_REG
);

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            is_rem_q, is_rem_d;
    logic [4:0]      dest_q, dest_d;
    logic [4:0]      out_dest_q, out_dest_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [XLEN:0]   trial;
    logic            signed_op, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, quot_fix, rem_fix;

    always_comb begin
        state_d    = state_q;
        is_rem_d   = is_rem_q;
        dest_d     = dest_q;
        out_dest_d = out_dest_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        result_d   = result_q;
        cnt_d      = cnt_q;

        signed_op = ~DIV_OP[0];
        a_neg     = signed_op & DIVIDEND[XLEN-1];
        b_neg     = signed_op & DIVISOR[XLEN-1];
        // Negating 0x80000000 yields 0x80000000, which read unsigned is the correct magnitude 2^31.
        a_mag     = a_neg ? -DIVIDEND : DIVIDEND;
        b_mag     = b_neg ? -DIVISOR : DIVISOR;

        // Remainder stays below the divisor, so bit XLEN of the 33-bit difference is a valid sign.
        trial     = {rem_q, quot_q[XLEN-1]} - {1'b0, divisor_q};
        quot_fix  = neg_quot_q ? -quot_q : quot_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (START && !FLUSH) begin
                    is_rem_d   = DIV_OP[1];
                    dest_d     = DEST_REG;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    divisor_d  = b_mag;
                    quot_d     = a_mag;
                    rem_d      = '0;
                    cnt_d      = CW'(ITER - 1);
                    if (DIVISOR == '0) begin
                        result_d   = DIV_OP[1] ? DIVIDEND : '1;
                        out_dest_d = DEST_REG;
                        state_d    = S_DONE;
                    end else if (signed_op && DIVIDEND == MIN_NEG && DIVISOR == '1) begin
                        result_d   = DIV_OP[1] ? '0 : MIN_NEG;
                        out_dest_d = DEST_REG;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = trial[XLEN] ? {rem_q[XLEN-2:0], quot_q[XLEN-1]} : trial[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], ~trial[XLEN]};
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    result_d   = is_rem_q ? rem_fix : quot_fix;
                    out_dest_d = dest_q;
                    state_d    = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            is_rem_q   <= 1'b0;
            dest_q     <= '0;
            out_dest_q <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_rem_q   <= is_rem_d;
            dest_q     <= dest_d;
            out_dest_q <= out_dest_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign RESULT       = result_q;
    assign OUT_DEST_REG = out_dest_q;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divider in the EX stage.
- Consumes the operands, ALU_OP and destination register as they leave the ID/EX pipeline register. Executes DIV, DIVU, REM and REMU over multiple cycles.
- Asserts BUSY back to hazard control, which holds the PC, IF/ID and ID/EX registers while it is high.
- Presents the result and destination register with a one-cycle DONE pulse toward EX/MEM.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, quotient bits produced, one per CALC cycle; must equal XLEN.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- START  input  1  a divide op is in EX; sampled only in IDLE.
- DIV_OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- DIVIDEND  input  32  rs1 value (forwarded operand 1).
- DIVISOR  input  32  rs2 value (forwarded operand 2).
- DEST_REG  input  5  rd of the divide instruction.
- FLUSH  input  1  kill the in-flight operation (branch/jump redirect).
- BUSY  output  1  operation accepted and not yet complete; stall request.
- DONE  output  1  one-cycle pulse; RESULT and OUT_DEST_REG are valid.
- RESULT  output  32  quotient or remainder.
- OUT_DEST_REG  output  5  rd captured at START.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, BUSY=0, DONE=0, RESULT=0, OUT_DEST_REG=0, and all internal registers cleared. Reset mid-operation abandons the operation with no DONE pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, START=1, FLUSH=0:
  - Capture DIV_OP and DEST_REG.
  - Signed ops (DIV/REM): latch the sign of each operand and store magnitudes. Unsigned ops: store raw values.
  - Special cases go IDLE->DONE:
    - divisor==0: quotient=32'hFFFFFFFF, remainder=DIVIDEND.
    - Signed overflow (DIVIDEND=32'h80000000, DIVISOR=32'hFFFFFFFF, DIV/REM): quotient=32'h80000000, remainder=0.
  - Otherwise IDLE->CALC with counter=31, partial remainder=0.
- IDLE, START=0 or FLUSH=1: stay in IDLE.
- CALC, restoring radix-2, one bit per cycle:
  - trial = {rem[31:0], q[31]} - divisor (33-bit).
  - trial non-negative: rem = trial[31:0], shift in quotient bit 1. Else shift in 0.
  - counter decrements; counter==0 -> FIX.
- FIX, sign correction:
  - Quotient negated when the operand signs differ.
  - Remainder negated when the dividend was negative.
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU) into RESULT. -> DONE.
- DONE: DONE=1 for exactly one cycle; RESULT and OUT_DEST_REG stable. -> IDLE.
- RESULT and OUT_DEST_REG hold their last values until the next completion.
- BUSY = 1 in CALC and FIX; 0 in IDLE and DONE.
- Latency, normal path:
  - START sampled at edge 0.
  - CALC on edges 1..32, FIX on edge 33; DONE is high during the cycle after edge 33.
  - BUSY high for 33 cycles, i.e. 34 cycles START-to-DONE.
- Latency, special case: DONE is high the cycle after START; BUSY never asserts.
- START while BUSY or in DONE: ignored. Hazard control holds ID/EX stable, so no second op is presented.
- Back-to-back: START may be asserted in the cycle DONE is high, but it is not sampled until the next IDLE cycle. A new op is accepted 1 cycle after DONE.
- FLUSH in CALC/FIX/DONE: next edge -> IDLE, no DONE pulse, BUSY=0. FLUSH takes priority over START in IDLE.
- FLUSH and RESET together: RESET wins.
- Internal arithmetic widths: 33-bit trial subtraction; 32-bit magnitudes. Magnitude of 32'h80000000 is 2^31, held unsigned.

Test Plan:
- Unsigned DIVU 100/7, DEST_REG=5 -> BUSY high 33 cycles, then DONE pulse: RESULT=14, OUT_DEST_REG=5. REMU of the same operands -> RESULT=2.
- Signed DIV -7/2 -> RESULT=32'hFFFFFFFD (-3). REM -7/2 -> 32'hFFFFFFFF (-1). REM 7/-2 -> 1.
- Divide by zero, DIV 1234/0 -> DONE the next cycle, RESULT=32'hFFFFFFFF, BUSY never 1. REMU 1234/0 -> RESULT=1234.
- Overflow, DIV 32'h80000000/32'hFFFFFFFF -> RESULT=32'h80000000 after 1 cycle. REM of the same operands -> 0.
- FLUSH on CALC cycle 10 -> BUSY=0 the next cycle, no DONE, RESULT unchanged. A following DIVU 9/3 -> RESULT=3 with full latency.
- RESET pulled low mid-CALC (cycle 20) -> BUSY, DONE, RESULT and OUT_DEST_REG=0 immediately (asynchronous). After RESET returns high, the unit accepts a fresh START.
